// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise / round / pack stage following the binary32 adder.
// It takes the raw adder result (sign, biased exponent of the larger operand,
// and a 28-bit extended magnitude with G/R/S bits). It normalises the value
// with a leading-zero count and rounds it using the RISC-V rounding mode. It
// then packs an IEEE 754 binary32 word and raises the accrued-exception flags.
// Subnormal results flush to signed zero.
//
// The block is a two-deep valid/ready pipeline: stage 1 (normalise) and stage 2
// (round/pack, held directly in the out_* registers). in_ready is purely
// combinational back-pressure; with both sides ready one result per cycle.
//
// Ports
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   flush                       squashes every in-flight entry at the next edge
//   in_valid / in_ready         upstream handshake
//   in_sign, in_exp, in_mant    raw adder result; in_mant = {carry, hidden, frac[22:0], G, R, S}
//   in_rm                       0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 act as RNE
//   in_special, in_spec_val,
//   in_spec_nv                  pre-determined result (NaN/inf/zero operand) and its NV flag
//   out_valid / out_ready       downstream handshake
//   out_result, out_flags       packed binary32 and {NV, DZ, OF, UF, NX}
module fp_norm_round #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0]        in_rm,
  input  logic              in_special,
  input  logic [31:0]       in_spec_val,
  input  logic              in_spec_nv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [4:0]        out_flags
);

  // Two guard bits let the exponent go negative after normalisation or exceed
  // the format range after rounding without wrapping.
  localparam int XW     = EXP_W + 2;
  localparam int FRAC_W = MANT_W - 5;
  localparam int LZ_W   = $clog2(FRAC_W + 1);

  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXP_W) - 1);

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [4:0] FLAG_OF = 5'b00100;
  localparam logic [4:0] FLAG_UF = 5'b00010;
  localparam logic [4:0] FLAG_NX = 5'b00001;

  // Leading zeros above the G bit. An all-zero field never reaches the shift
  // (exact zero is caught first) unless only G/R/S are set; the count then
  // saturates so the shift stays within the field.
  function automatic logic [LZ_W-1:0] lzc(input logic [FRAC_W:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(FRAC_W);
    for (int i = 0; i <= FRAC_W; i++)
      if (v[i]) n = LZ_W'(FRAC_W - i);
    return n;
  endfunction

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic [2:0] grs);
    logic inexact;
    inexact = |grs;
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return inexact & sign;
      RM_RUP:  return inexact & ~sign;
      RM_RMM:  return grs[2];
      default: return grs[2] & (grs[1] | grs[0] | lsb);
    endcase
  endfunction

  // Overflow saturates to infinity only when the rounding direction points
  // away from zero for this sign; otherwise to the largest finite magnitude.
  function automatic logic [31:0] sat_overflow(input logic [2:0] rm, input logic sign);
    logic to_inf;
    case (rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign;
      RM_RUP:  to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    if (to_inf) return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    return {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
  endfunction

  logic adv_p1, adv_p2;
  logic vld_p1;

  assign adv_p2   = ~out_valid | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;

  // ---- stage 0 -> 1: normalise ----
  logic signed [XW-1:0] exp_ext_p0, norm_exp_p0;
  logic [MANT_W-3:0]    norm_mant_p0;
  logic [LZ_W-1:0]      lz_p0;
  logic                 is_zero_p0, bypass_p0;
  logic [31:0]          fix_res_p0;
  logic [4:0]           fix_flags_p0;

  always_comb begin
    exp_ext_p0   = signed'({2'b00, in_exp});
    lz_p0        = lzc(in_mant[MANT_W-2:3]);
    norm_mant_p0 = '0;
    norm_exp_p0  = exp_ext_p0;
    is_zero_p0   = 1'b0;
    if (in_mant[MANT_W-1]) begin
      // Carry out of the add: drop to the hidden position, folding the lost
      // bit into sticky.
      norm_mant_p0 = {in_mant[MANT_W-2:2], in_mant[1] | in_mant[0]};
      norm_exp_p0  = exp_ext_p0 + EXP_ONE;
    end else if (in_mant[MANT_W-2:0] == '0) begin
      is_zero_p0 = 1'b1;
    end else begin
      // The hidden bit lands at bit MANT_W-2 and falls off this narrower
      // vector, leaving only fraction and G/R/S.
      norm_mant_p0 = in_mant[MANT_W-3:0] << lz_p0;
      norm_exp_p0  = exp_ext_p0 - signed'(XW'(lz_p0));
    end

    bypass_p0    = 1'b1;
    fix_res_p0   = {in_sign, 31'b0};
    fix_flags_p0 = '0;
    if (in_special) begin
      fix_res_p0   = in_spec_val;
      fix_flags_p0 = {in_spec_nv, 4'b0};
    end else if (!is_zero_p0) begin
      if (norm_exp_p0 <= EXP_ZERO) fix_flags_p0 = FLAG_UF | FLAG_NX;
      else                         bypass_p0    = 1'b0;
    end
  end

  logic                 sign_p1, bypass_p1;
  logic signed [XW-1:0] exp_p1;
  logic [FRAC_W-1:0]    frac_p1;
  logic [2:0]           grs_p1, rm_p1;
  logic [31:0]          fix_res_p1;
  logic [4:0]           fix_flags_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     vld_p1 <= 1'b0;
    else if (flush)  vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && adv_p1 && !flush) begin
      sign_p1      <= in_sign;
      exp_p1       <= norm_exp_p0;
      frac_p1      <= norm_mant_p0[MANT_W-3:3];
      grs_p1       <= norm_mant_p0[2:0];
      rm_p1        <= in_rm;
      bypass_p1    <= bypass_p0;
      fix_res_p1   <= fix_res_p0;
      fix_flags_p1 <= fix_flags_p0;
    end
  end

  // ---- stage 1 -> 2: round and pack ----
  logic                 inc_p1, carry_p1, nx_p1;
  logic [FRAC_W-1:0]    frac_rnd_p1;
  logic signed [XW-1:0] exp_rnd_p1;
  logic [31:0]          res_p1;
  logic [4:0]           flags_p1;

  always_comb begin
    inc_p1      = round_inc(rm_p1, sign_p1, frac_p1[0], grs_p1);
    // All-ones fraction plus one wraps to zero and bumps the exponent.
    carry_p1    = inc_p1 & (&frac_p1);
    frac_rnd_p1 = frac_p1 + FRAC_W'(inc_p1);
    exp_rnd_p1  = exp_p1 + signed'(XW'(carry_p1));
    nx_p1       = |grs_p1;
    res_p1      = {sign_p1, exp_rnd_p1[EXP_W-1:0], frac_rnd_p1};
    flags_p1    = {4'b0, nx_p1};
    if (bypass_p1) begin
      res_p1   = fix_res_p1;
      flags_p1 = fix_flags_p1;
    end else if (exp_rnd_p1 >= EXP_INF) begin
      res_p1   = sat_overflow(rm_p1, sign_p1);
      flags_p1 = FLAG_OF | FLAG_NX;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_result <= res_p1;
        out_flags  <= flags_p1;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors through a scoreboard
// queue, plus handshake, back-pressure, flush and asynchronous reset scenarios.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic [2:0]  in_rm;
  logic        in_special, in_spec_nv;
  logic [31:0] in_spec_val;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  always #5 clk = ~clk;

  fp_norm_round #(.MANT_W(28), .EXP_W(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_rm(in_rm),
    .in_special(in_special), .in_spec_val(in_spec_val), .in_spec_nv(in_spec_nv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [2:0]  rm;
    logic        spec;
    logic [31:0] sval;
    logic        snv;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  exp_t drv_exp;
  exp_t e;

  int nchecks = 0;
  int nerr = 0;

  logic        acc, got;
  logic [31:0] got_res;
  logic [4:0]  got_flg;

  task automatic add_vec(input logic sign, input logic [7:0] ex, input logic [27:0] mant,
                         input logic [2:0] rm, input logic [31:0] res, input logic [4:0] flg);
    vec_t v;
    v = '{sign: sign, exp: ex, mant: mant, rm: rm, spec: 1'b0, sval: 32'h0, snv: 1'b0,
          res: res, flg: flg};
    vt.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_sign     = v.sign;
    in_exp      = v.exp;
    in_mant     = v.mant;
    in_rm       = v.rm;
    in_special  = v.spec;
    in_spec_val = v.sval;
    in_spec_nv  = v.snv;
    drv_exp     = '{res: v.res, flg: v.flg};
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_special = 1'b0;
  endtask

  // Called at a falling edge with inputs already set; samples both handshakes
  // mid low phase, records accepted stimulus, returns at the next falling edge.
  task automatic step();
    #1;
    acc     = in_valid & in_ready & ~flush;
    got     = out_valid & out_ready;
    got_res = out_result;
    got_flg = out_flags;
    if (acc) sb.push_back(drv_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_rm = '0; in_spec_val = '0; in_spec_nv = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    nchecks++; if (out_result !== 32'h0) begin nerr++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
    nchecks++; if (out_flags !== 5'h0) begin nerr++; $display("FAIL reset_out_flags got=%b want=00000", out_flags); end
    resetn = 1'b1;
    @(negedge clk);
    nchecks++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    vec_t v;
    v = '{sign: 1'b0, exp: 8'd127, mant: 28'h8000000, rm: 3'd0, spec: 1'b0, sval: 32'h0,
          snv: 1'b0, res: 32'h40000000, flg: 5'h00};
    out_ready = 1'b1;
    drive(v);
    step();
    idle();
    nchecks++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL lat_early got=%b want=0", out_valid); end
    step();
    nchecks++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    nchecks++; if (out_result !== 32'h40000000) begin nerr++; $display("FAIL lat_result got=%h want=40000000", out_result); end
    step();
    nchecks++;
    if (!got || sb.size() == 0) begin
      nerr++; $display("FAIL lat_pop got=%b queued=%0d want transfer", got, sb.size());
    end else begin
      e = sb.pop_front();
      if (got_res !== e.res || got_flg !== e.flg) begin
        nerr++; $display("FAIL lat_data got=%h/%b want=%h/%b", got_res, got_flg, e.res, e.flg);
      end
    end
    nchecks++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL lat_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_vectors();
    vec_t s;
    int   seen;
    vt.delete();
    add_vec(1'b0, 8'd127, 28'h8000000,                     3'd0, 32'h40000000, 5'h00); // 1+1
    add_vec(1'b0, 8'd127, 28'h0000008,                     3'd0, 32'h34000000, 5'h00); // cancellation
    add_vec(1'b0, 8'd127, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 3'd0, 32'h40000000, 5'h01); // RNE tie up
    add_vec(1'b0, 8'd127, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 3'd1, 32'h3FFFFFFF, 5'h01); // RTZ
    add_vec(1'b0, 8'd127, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 3'd7, 32'h40000000, 5'h01); // rm 7 = RNE
    add_vec(1'b0, 8'd254, 28'h8000000,                     3'd0, 32'h7F800000, 5'h05); // OF RNE
    add_vec(1'b0, 8'd254, 28'h8000000,                     3'd1, 32'h7F7FFFFF, 5'h05); // OF RTZ
    add_vec(1'b0, 8'd254, 28'h8000000,                     3'd2, 32'h7F7FFFFF, 5'h05); // OF RDN +
    add_vec(1'b1, 8'd254, 28'h8000000,                     3'd2, 32'hFF800000, 5'h05); // OF RDN -
    add_vec(1'b1, 8'd254, 28'h8000000,                     3'd3, 32'hFF7FFFFF, 5'h05); // OF RUP -
    add_vec(1'b0, 8'd254, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 3'd0, 32'h7F800000, 5'h05); // round into OF
    add_vec(1'b1, 8'd127, 28'h4000001,                     3'd2, 32'hBF800001, 5'h01); // RDN neg
    add_vec(1'b1, 8'd127, 28'h4000001,                     3'd3, 32'hBF800000, 5'h01); // RUP neg
    add_vec(1'b0, 8'd127, 28'h4000001,                     3'd3, 32'h3F800001, 5'h01); // RUP pos
    add_vec(1'b0, 8'd127, 28'h4000004,                     3'd4, 32'h3F800001, 5'h01); // RMM tie
    add_vec(1'b0, 8'd127, 28'h4000004,                     3'd0, 32'h3F800000, 5'h01); // RNE tie even
    add_vec(1'b0, 8'd127, 28'h8000003,                     3'd0, 32'h40000000, 5'h01); // carry sticky
    add_vec(1'b1, 8'd100, 28'h0000000,                     3'd0, 32'h80000000, 5'h00); // exact zero
    add_vec(1'b0, 8'd1,   28'h2000000,                     3'd0, 32'h00000000, 5'h03); // flush to zero
    s = '{sign: 1'b0, exp: 8'd255, mant: 28'h4000000, rm: 3'd0, spec: 1'b1, sval: 32'h7FC00000,
          snv: 1'b1, res: 32'h7FC00000, flg: 5'h10};
    vt.push_back(s);                                                                         // special
    out_ready = 1'b1;
    seen = 0;
    foreach (vt[i]) begin
      drive(vt[i]);
      step();
      nchecks++; if (!acc) begin nerr++; $display("FAIL vec_accept idx=%0d in_ready=%b want=1", i, in_ready); end
      if (got) begin
        seen++;
        e = sb.pop_front();
        nchecks++; if (got_res !== e.res) begin nerr++; $display("FAIL vec_result n=%0d got=%h want=%h", seen, got_res, e.res); end
        nchecks++; if (got_flg !== e.flg) begin nerr++; $display("FAIL vec_flags n=%0d got=%b want=%b", seen, got_flg, e.flg); end
      end
    end
    idle();
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      step();
      if (got) begin
        seen++;
        e = sb.pop_front();
        nchecks++; if (got_res !== e.res) begin nerr++; $display("FAIL vec_result n=%0d got=%h want=%h", seen, got_res, e.res); end
        nchecks++; if (got_flg !== e.flg) begin nerr++; $display("FAIL vec_flags n=%0d got=%b want=%b", seen, got_flg, e.flg); end
      end
    end
    nchecks++; if (sb.size() != 0) begin nerr++; $display("FAIL vec_drain left=%0d want=0", sb.size()); end
    nchecks++; if (seen != vt.size()) begin nerr++; $display("FAIL vec_count got=%0d want=%0d", seen, vt.size()); end
  endtask

  task automatic test_backpressure();
    int idx;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(vt[idx]);
      step();
      if (acc) idx++;
      if (c > 0) begin
        nchecks++; if (out_valid !== 1'b1 || out_result !== vt[0].res) begin
          nerr++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", c, out_valid, out_result, vt[0].res);
        end
      end
    end
    nchecks++; if (idx != 2) begin nerr++; $display("FAIL bp_accepted got=%0d want=2", idx); end
    nchecks++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && (idx < 3 || sb.size() > 0); c++) begin
      if (idx < 3) drive(vt[idx]); else idle();
      step();
      if (acc) idx++;
      if (got) begin
        e = sb.pop_front();
        nchecks++; if (got_res !== e.res || got_flg !== e.flg) begin
          nerr++; $display("FAIL bp_order got=%h/%b want=%h/%b", got_res, got_flg, e.res, e.flg);
        end
      end
    end
    idle();
    nchecks++; if (idx != 3 || sb.size() != 0) begin nerr++; $display("FAIL bp_drain accepted=%0d left=%0d want=3/0", idx, sb.size()); end
  endtask

  task automatic test_flush();
    int seen_valid;
    out_ready = 1'b0;
    drive(vt[5]); step();
    drive(vt[6]); step();
    nchecks++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fl_inflight got=%b want=1", out_valid); end
    drive(vt[2]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    nchecks++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fl_out_valid got=%b want=0", out_valid); end
    sb.delete();
    out_ready = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (got) seen_valid++;
    end
    nchecks++; if (seen_valid != 0) begin nerr++; $display("FAIL fl_stale got=%0d results want=0", seen_valid); end
    drive(vt[1]); step(); idle();
    for (int c = 0; c < 6 && sb.size() > 0; c++) begin
      step();
      if (got) begin
        e = sb.pop_front();
        nchecks++; if (got_res !== e.res || got_flg !== e.flg) begin
          nerr++; $display("FAIL fl_after got=%h/%b want=%h/%b", got_res, got_flg, e.res, e.flg);
        end
      end
    end
    nchecks++; if (sb.size() != 0) begin nerr++; $display("FAIL fl_timeout left=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int seen_valid;
    out_ready = 1'b0;
    drive(vt[3]); step();
    drive(vt[4]); step();
    idle();
    #2 resetn = 1'b0;
    #1;
    nchecks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 5'h0) begin
      nerr++; $display("FAIL rst_mid got=%b/%h/%b want=0/00000000/00000", out_valid, out_result, out_flags);
    end
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (got) seen_valid++;
    end
    nchecks++; if (seen_valid != 0) begin nerr++; $display("FAIL rst_stale got=%0d results want=0", seen_valid); end
    nchecks++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    nerr++;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", nerr, nchecks);
    $fatal(1, "watchdog");
  end

endmodule
